priority_encoder_4x2: RTL and testbench
=======================================

// Module: priority_encoder_4x2
// PURPOSE
//   Keypad digit encoder for the microwave controller (Level 3, Encoder).
//   Converts a 10-bit key vector (bit i = digit key i) into a 4-bit BCD digit.
//   The highest-numbered pressed key wins. The result is registered, so the
//   time-entry logic downstream sees a clean, clocked digit plus a
//   key-valid flag and a one-cycle new-key strobe.
// PARAMETERS
//   NUM_KEYS  10  number of key inputs; only 10 is supported
//   OUT_W      4  width of encoded output; must satisfy 2**OUT_W >= NUM_KEYS
// PORTS
//   clk      in   1   system clock; all state updates on the rising edge
//   rst      in   1   synchronous reset, active-high
//   enable   in   1   1 = sample and encode; 0 = freeze all outputs
//   number   in  10   key vector; bit i high = digit i pressed; any bits may be set
//   encoded  out  4   registered BCD index of the highest set bit of number
//   valid    out  1   registered; 1 = at least one key was set at the last enabled sample
//   new_key  out  1   one-cycle pulse on a none->some key transition
// BEHAVIOUR
//   - Clock and reset: one clock domain. One-cycle latency from number to outputs.
//   - Reset: rst=1 at a rising edge gives encoded=4'd0, valid=0, new_key=0.
//     Reset has priority over enable.
//   - Encoding: on a rising edge with rst=0 and enable=1:
//     - number != 0: encoded <= index of the most-significant 1 in number[9:0];
//       valid <= 1.
//     - number == 0: encoded holds its previous value; valid <= 0.
//   - Strobe, with rst=0 and enable=1: new_key <= (number != 0) & ~valid.
//     This means exactly one pulse per press after an idle sample. A change of
//     digit while a key stays held does not pulse.
//   - enable=0 at a rising edge: encoded and valid hold; new_key <= 0.
//   - Priority examples:
//     - 10'b10_0000_0001 -> 9
//     - 10'b00_0001_0100 -> 4
//     - 10'b00_0000_0001 -> 0 with valid=1, which is distinct from "no key" (valid=0).
//   - Output range: encoded never exceeds 9. Codes 10..15 are never produced.
//   - Combinational path: number -> register only. There is no combinational
//     path from any input to any output.
//   - Reset mid-operation: the cycle after rst, outputs are the reset values
//     regardless of number. The first enabled sample with a key afterwards
//     pulses new_key.
//   - X/Z on number is not handled. The bench drives known values only.
// TESTING
//   - Reset: rst=1 for 2 cycles with number=10'h3FF, enable=1
//     -> encoded=0, valid=0, new_key=0.
//   - One-hot sweep: enable=1; drive number=1<<k for k=8 down to 0, holding each
//     for 2+ cycles -> one edge later encoded=k, valid=1.
//   - Multi-key priority: 10'b10_0000_0001 -> 9; 10'b00_0011_0000 -> 5;
//     10'b00_0000_0110 -> 2.
//   - Idle/hold: after number=10'b00_0100_0000 (encoded=6), drive number=0
//     -> encoded stays 6, valid=0.
//   - Strobe: number 0 -> 10'b00_0000_1000 -> new_key=1 for exactly one cycle,
//     encoded=3. Then switch to 10'b00_0001_0000 while held -> encoded=4,
//     no pulse.
//   - Enable gating: enable=0, change number 7->2 -> encoded stays 7 and
//     new_key=0. Re-enable -> encoded=2 one edge later.

Source files
------------

// File: rtl/priority_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_4x2
// Description : Keypad digit encoder for the microwave controller. Converts a
//               one-bit-per-key vector into the BCD digit of the highest
//               pressed key. The digit, a key-valid flag and a one-cycle
//               new-key strobe are all registered.
// Ports       :
//   clk      in   1         system clock, rising edge
//   rst      in   1         synchronous reset, active-high (beats enable)
//   enable   in   1         1 = sample and encode, 0 = freeze outputs
//   number   in   NUM_KEYS  key vector, bit i high = digit i pressed
//   encoded  out  OUT_W     BCD index of highest pressed key (held when idle)
//   valid    out  1         a key was pressed at the last enabled sample
//   new_key  out  1         one-cycle pulse on an idle -> pressed transition
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_4x2 #(
    parameter int NUM_KEYS = 10,
    parameter int OUT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] number,
    output logic [OUT_W-1:0]    encoded,
    output logic                valid,
    output logic                new_key
);

    // ------------------------------------------------------------------------
    // Combinational priority search
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] w_msb_idx;
    logic             w_any_key;

    // Ascending scan: a later (higher) set bit overwrites any lower one, so the
    // final value is the index of the most-significant pressed key.
    always_comb begin
        w_msb_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (number[i]) begin
                w_msb_idx = OUT_W'(i);
            end
        end
    end

    assign w_any_key = |number;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] encoded_d, encoded_q;
    logic             valid_d,   valid_q;
    logic             new_key_d, new_key_q;

    always_comb begin
        encoded_d = encoded_q;
        valid_d   = valid_q;
        new_key_d = 1'b0;
        if (enable) begin
            // With no key pressed the last digit is kept so the downstream
            // logic can still read it; only valid drops.
            if (w_any_key) begin
                encoded_d = w_msb_idx;
            end
            valid_d   = w_any_key;
            // Pulse only when coming out of an idle sample; a digit change
            // while a key stays held does not re-trigger.
            new_key_d = w_any_key & ~valid_q;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            encoded_q <= '0;
            valid_q   <= 1'b0;
            new_key_q <= 1'b0;
        end else begin
            encoded_q <= encoded_d;
            valid_q   <= valid_d;
            new_key_q <= new_key_d;
        end
    end

    // Outputs come straight from flops: no input-to-output combinational path.
    assign encoded = encoded_q;
    assign valid   = valid_q;
    assign new_key = new_key_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_4x2
// Description : Scoreboard bench for priority_encoder_4x2. A driver applies
//               directed vectors and queues the hand-computed response; a
//               monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_4x2;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [9:0] number;
    logic [3:0] encoded;
    logic       valid;
    logic       new_key;

    priority_encoder_4x2 #(
        .NUM_KEYS (10),
        .OUT_W    (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .number  (number),
        .encoded (encoded),
        .valid   (valid),
        .new_key (new_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] enc;
        logic       val;
        logic       nk;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    // Drive one vector at the falling edge; its response is visible after the
    // following rising edge.
    task automatic step(input logic r, input logic e, input logic [9:0] n,
                        input logic [3:0] ee, input logic ev, input logic en);
        exp_t x;
        @(negedge clk);
        rst    = r;
        enable = e;
        number = n;
        x.enc  = ee;
        x.val  = ev;
        x.nk   = en;
        x.id   = vec_id;
        exp_q.push_back(x);
        vec_id++;
    endtask

    // Monitor: every edge produces a registered output, so one pop per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (encoded !== x.enc) begin
                errors++;
                $display("FAIL vec%0d encoded: got %0d expected %0d", x.id, encoded, x.enc);
            end
            checks++;
            if (valid !== x.val) begin
                errors++;
                $display("FAIL vec%0d valid: got %b expected %b", x.id, valid, x.val);
            end
            checks++;
            if (new_key !== x.nk) begin
                errors++;
                $display("FAIL vec%0d new_key: got %b expected %b", x.id, new_key, x.nk);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        number = 10'h3FF;

        // Reset for two cycles with all keys pressed
        step(1, 1, 10'h3FF, 4'd0, 0, 0);
        step(1, 1, 10'h3FF, 4'd0, 0, 0);

        // One-hot sweep 8..0, two cycles each; only the first press pulses
        for (int k = 8; k >= 0; k--) begin
            step(0, 1, 10'(1 << k), 4'(k), 1, (k == 8));
            step(0, 1, 10'(1 << k), 4'(k), 1, 1'b0);
        end

        // Release: digit 0 held, valid drops
        step(0, 1, 10'b00_0000_0000, 4'd0, 0, 0);

        // Multi-key priority
        step(0, 1, 10'b10_0000_0001, 4'd9, 1, 1);
        step(0, 1, 10'b00_0011_0000, 4'd5, 1, 0);
        step(0, 1, 10'b00_0000_0110, 4'd2, 1, 0);

        // Idle hold
        step(0, 1, 10'b00_0100_0000, 4'd6, 1, 0);
        step(0, 1, 10'b00_0000_0000, 4'd6, 0, 0);
        step(0, 1, 10'b00_0000_0000, 4'd6, 0, 0);

        // Strobe: single pulse, no pulse on a held digit change
        step(0, 1, 10'b00_0000_1000, 4'd3, 1, 1);
        step(0, 1, 10'b00_0000_1000, 4'd3, 1, 0);
        step(0, 1, 10'b00_0001_0000, 4'd4, 1, 0);
        step(0, 1, 10'b00_0001_0000, 4'd4, 1, 0);

        // Enable gating 7 -> 2
        step(0, 1, 10'b00_1000_0000, 4'd7, 1, 0);
        step(0, 0, 10'b00_0000_0100, 4'd7, 1, 0);
        step(0, 0, 10'b00_0000_0100, 4'd7, 1, 0);
        step(0, 1, 10'b00_0000_0100, 4'd2, 1, 0);

        // Disabled press from idle must not pulse; pulse comes on re-enable
        step(0, 1, 10'b00_0000_0000, 4'd2, 0, 0);
        step(0, 0, 10'b10_0000_0000, 4'd2, 0, 0);
        step(0, 1, 10'b10_0000_0000, 4'd9, 1, 1);

        // Reset mid-operation, then first enabled key pulses
        step(1, 1, 10'h3FF, 4'd0, 0, 0);
        step(0, 1, 10'h3FF, 4'd9, 1, 1);
        step(0, 1, 10'b00_0000_0001, 4'd0, 1, 0);

        // Reset wins over enable=0
        step(1, 0, 10'h3FF, 4'd0, 0, 0);
        step(0, 1, 10'b00_0000_0001, 4'd0, 1, 1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
